cache_arbiter: RTL and testbench

- Shares the single physical-memory port between the I-cache and the D-cache of the pipelined RV32I core.
- Sits between both caches' pmem interfaces and main memory.
- Grants one cache-line transaction at a time, latches its address/data and routes the response back to the winner only.
- D-cache wins simultaneous requests by default, because a data miss stalls the whole pipeline.

---
 rtl/cache_arbiter.sv | 104 ++++++++++
 tb/tb_cache_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache, one line transaction at a time.
// Optional macro CACHE_ARBITER_FAIR_EN enables alternating priority on simultaneous requests.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  logic   d_req;
  logic   grant_d;

  assign d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARBITER_FAIR_EN
  // prio_d set means the D-cache wins a tie; it points away from the last winner.
  logic prio_d;
  assign grant_d = d_req & (~i_pmem_read | prio_d);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
`ifdef CACHE_ARBITER_FAIR_EN
      prio_d       <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            pmem_address <= d_pmem_address;
            pmem_wdata   <= d_pmem_wdata;
            pmem_write   <= d_pmem_write;
            pmem_read    <= ~d_pmem_write;
            state        <= SERVE_D;
          end else if (i_pmem_read) begin
            pmem_address <= i_pmem_address;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            state        <= SERVE_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            state      <= IDLE;
`ifdef CACHE_ARBITER_FAIR_EN
            prio_d     <= (state == SERVE_I);
`endif
          end
        end
        default: begin
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Response is a same-cycle pass-through so the winner sees memory latency + 1.
  assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

`ifndef SYNTHESIS
  a_d_op_exclusive : assert property (@(posedge clk) disable iff (rst)
                                      !(d_pmem_read && d_pmem_write))
    else $warning("cache_arbiter: d_pmem_read and d_pmem_write both high, write takes precedence");
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter; one task per scenario with inline comparisons.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam logic [LW-1:0] LINE_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] LINE_WR = {8{32'h1234_5678}};
  localparam logic [LW-1:0] LINE_3C = {32{8'h3C}};
  localparam logic [LW-1:0] LINE_ILL = {8{32'hCAFE_F00D}};

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    n_checks++; if ({pmem_read, pmem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {pmem_read, pmem_write}); end
    n_checks++; if (pmem_address !== '0) begin n_fail++; $display("FAIL reset_address got %h want 0", pmem_address); end
    n_checks++; if (pmem_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", pmem_wdata); end
    rst = 1'b0;
    pmem_resp = 1'b1;
    tick();
    n_checks++; if ({i_pmem_resp, d_pmem_resp, pmem_read} !== 3'b000) begin n_fail++; $display("FAIL idle_resp_ignored got %b want 000", {i_pmem_resp, d_pmem_resp, pmem_read}); end
    pmem_resp = 1'b0;
    tick();
  endtask

  task automatic test_lone_i();
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b1000) begin n_fail++; $display("FAIL lone_i_strobe cyc%0d got %b want 1000", k, {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}); end
      n_checks++; if (pmem_address !== 32'h0000_1000) begin n_fail++; $display("FAIL lone_i_addr got %h want 00001000", pmem_address); end
    end
    pmem_rdata = LINE_A5;
    pmem_resp  = 1'b1;
    #1;
    n_checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin n_fail++; $display("FAIL lone_i_resp got %b want 10", {i_pmem_resp, d_pmem_resp}); end
    n_checks++; if (i_pmem_rdata !== LINE_A5) begin n_fail++; $display("FAIL lone_i_rdata got %h want %h", i_pmem_rdata, LINE_A5); end
    tick();
    pmem_resp   = 1'b0;
    i_pmem_read = 1'b0;
    #1;
    n_checks++; if ({pmem_read, pmem_write, i_pmem_resp} !== 3'b000) begin n_fail++; $display("FAIL lone_i_done got %b want 000", {pmem_read, pmem_write, i_pmem_resp}); end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [AW-1:0] first_addr;
    logic [AW-1:0] second_addr;
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0100;
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_0200;
    tick();
    n_checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_0200}) begin n_fail++; $display("FAIL simul_d_first got rd=%b addr=%h want rd=1 addr=00000200", pmem_read, pmem_address); end
    pmem_resp = 1'b1;
    #1;
    n_checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin n_fail++; $display("FAIL simul_d_resp got %b want 01", {i_pmem_resp, d_pmem_resp}); end
    tick();
    pmem_resp      = 1'b0;
    d_pmem_address = 32'h0000_0300;
    #1;
    n_checks++; if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin n_fail++; $display("FAIL simul_gap got %b want 0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}); end
`ifdef CACHE_ARBITER_FAIR_EN
    first_addr  = 32'h0000_0100;
    second_addr = 32'h0000_0300;
`else
    first_addr  = 32'h0000_0300;
    second_addr = 32'h0000_0100;
`endif
    tick();
    n_checks++; if ({pmem_read, pmem_address} !== {1'b1, first_addr}) begin n_fail++; $display("FAIL simul_pair2_first got rd=%b addr=%h want rd=1 addr=%h", pmem_read, pmem_address, first_addr); end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    if (first_addr == 32'h0000_0100) i_pmem_read = 1'b0;
    else d_pmem_read = 1'b0;
    tick();
    n_checks++; if ({pmem_read, pmem_address} !== {1'b1, second_addr}) begin n_fail++; $display("FAIL simul_pair2_second got rd=%b addr=%h want rd=1 addr=%h", pmem_read, pmem_address, second_addr); end
    pmem_resp = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_d_writeback();
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_2040;
    d_pmem_wdata   = LINE_WR;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++; if ({pmem_write, pmem_read, d_pmem_resp} !== 3'b100) begin n_fail++; $display("FAIL wb_strobe cyc%0d got %b want 100", k, {pmem_write, pmem_read, d_pmem_resp}); end
      n_checks++; if ({pmem_address, pmem_wdata} !== {32'h0000_2040, LINE_WR}) begin n_fail++; $display("FAIL wb_stable cyc%0d got addr=%h want 00002040", k, pmem_address); end
      if (k == 1) begin
        d_pmem_address = 32'h0000_DEAD;
        d_pmem_wdata   = LINE_3C;
      end
      if (k < 4) tick();
    end
    pmem_resp = 1'b1;
    #1;
    n_checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin n_fail++; $display("FAIL wb_resp got %b want 01", {i_pmem_resp, d_pmem_resp}); end
    tick();
    clear_inputs();
    #1;
    n_checks++; if ({pmem_write, d_pmem_resp} !== 2'b00) begin n_fail++; $display("FAIL wb_done got %b want 00", {pmem_write, d_pmem_resp}); end
    tick();
  endtask

  task automatic test_late_arrival();
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0400;
    tick();
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_0500;
    tick();
    n_checks++; if ({pmem_address, d_pmem_resp} !== {32'h0000_0400, 1'b0}) begin n_fail++; $display("FAIL late_i_held got addr=%h dresp=%b want 00000400 0", pmem_address, d_pmem_resp); end
    pmem_resp = 1'b1;
    #1;
    n_checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin n_fail++; $display("FAIL late_i_resp got %b want 10", {i_pmem_resp, d_pmem_resp}); end
    tick();
    pmem_resp   = 1'b0;
    i_pmem_read = 1'b0;
    #1;
    n_checks++; if ({pmem_read, d_pmem_resp} !== 2'b00) begin n_fail++; $display("FAIL late_gap got %b want 00", {pmem_read, d_pmem_resp}); end
    tick();
    n_checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_0500}) begin n_fail++; $display("FAIL late_d_grant got rd=%b addr=%h want 1 00000500", pmem_read, pmem_address); end
    pmem_resp = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_midflight_reset();
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_0600;
    tick();
    n_checks++; if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL mid_rst_grant got %b want 1", pmem_read); end
    rst         = 1'b1;
    d_pmem_read = 1'b0;
    tick();
    rst = 1'b0;
    n_checks++; if ({pmem_read, pmem_write} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_strobes got %b want 00", {pmem_read, pmem_write}); end
    pmem_resp = 1'b1;
    #1;
    n_checks++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_late_resp got %b want 00", {i_pmem_resp, d_pmem_resp}); end
    tick();
    pmem_resp = 1'b0;
    tick();
  endtask

  task automatic test_illegal_op();
    d_pmem_read    = 1'b1;
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_0700;
    d_pmem_wdata   = LINE_ILL;
    tick();
    n_checks++; if ({pmem_write, pmem_read, pmem_wdata} !== {2'b10, LINE_ILL}) begin n_fail++; $display("FAIL illegal_write_wins got wr=%b rd=%b want wr=1 rd=0", pmem_write, pmem_read); end
    pmem_resp = 1'b1;
    #1;
    n_checks++; if (d_pmem_resp !== 1'b1) begin n_fail++; $display("FAIL illegal_resp got %b want 1", d_pmem_resp); end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_lone_i();
    test_simultaneous();
    test_d_writeback();
    test_late_arrival();
    test_midflight_reset();
    test_illegal_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
